// File: rtl/gpio_port.sv
// Memory-mapped GPIO port: MODE/IDATA/ODATA/INTCFG registers, a two-flop input
// synchronizer and two edge-triggered pending bits that drive irq0/irq1.
module gpio_port #(
    parameter int unsigned WIDTH     = 16,
    parameter logic [31:0] OUT_RESET = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       addr,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic [31:0]      wr_data,
    input  logic [3:0]       wr_strobe,
    output logic [31:0]      rd_data,
    output logic             rd_valid,
    output logic             err,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq0,
    output logic             irq1
);

    localparam logic [1:0] REG_MODE   = 2'd0;
    localparam logic [1:0] REG_IDATA  = 2'd1;
    localparam logic [1:0] REG_ODATA  = 2'd2;
    localparam logic [1:0] REG_INTCFG = 2'd3;

    logic [WIDTH-1:0] mode_q, mode_d;
    logic [WIDTH-1:0] odata_q, odata_d;
    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [4:0]       sel0_q, sel0_d, sel1_q, sel1_d;
    logic [1:0]       emode0_q, emode0_d, emode1_q, emode1_d;
    logic             pend0_q, pend0_d, pend1_q, pend1_d;
    logic             rd_valid_q, rd_valid_d;
    logic [31:0]      rd_data_q, rd_data_d;
    logic             err_q, err_d;

    logic             addr_ok_s;
    logic             wr_ok_s;
    logic             rd_ok_s;
    logic             hit0_s, hit1_s;
    logic             w1c0_s, w1c1_s;
    logic [31:0]      rd_word_s;

    // Byte-lane merge of a WIDTH-bit register; lane of bit i is i/8.
    function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_v,
                                                    input logic [31:0]      data_v,
                                                    input logic [3:0]       strb_v);
        logic [WIDTH-1:0] res;
        res = old_v;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (strb_v[i/8]) begin
                res[i] = data_v[i];
            end
        end
        return res;
    endfunction

    function automatic logic [31:0] zext(input logic [WIDTH-1:0] v);
        logic [31:0] res;
        res = 32'h0000_0000;
        res[WIDTH-1:0] = v;
        return res;
    endfunction

    // A SEL value at or beyond WIDTH matches no pin, so it can never hit.
    function automatic logic edge_hit(input logic [4:0]       sel_v,
                                      input logic [1:0]       emode_v,
                                      input logic [WIDTH-1:0] cur_v,
                                      input logic [WIDTH-1:0] prv_v);
        logic res;
        res = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (sel_v == 5'(i)) begin
                res = (emode_v[0] & cur_v[i] & ~prv_v[i]) |
                      (emode_v[1] & ~cur_v[i] & prv_v[i]);
            end
        end
        return res;
    endfunction

    // Decode, register writes, pending-bit update, read mux and pipeline inputs.
    always_comb begin
        addr_ok_s = (addr[1:0] == 2'b00);
        wr_ok_s   = wr_en & addr_ok_s;
        rd_ok_s   = rd_en & addr_ok_s;

        mode_d   = mode_q;
        odata_d  = odata_q;
        sel0_d   = sel0_q;
        sel1_d   = sel1_q;
        emode0_d = emode0_q;
        emode1_d = emode1_q;

        if (wr_ok_s) begin
            case (addr[3:2])
                REG_MODE:  mode_d  = lane_merge(mode_q, wr_data, wr_strobe);
                REG_IDATA: mode_d  = mode_q;
                REG_ODATA: odata_d = lane_merge(odata_q, wr_data, wr_strobe);
                REG_INTCFG: begin
                    if (wr_strobe[0]) begin
                        sel0_d   = wr_data[4:0];
                        emode0_d = wr_data[6:5];
                    end else begin
                        sel0_d   = sel0_q;
                    end
                    if (wr_strobe[1]) begin
                        sel1_d   = wr_data[12:8];
                        emode1_d = wr_data[14:13];
                    end else begin
                        sel1_d   = sel1_q;
                    end
                end
                default:   mode_d  = mode_q;
            endcase
        end else begin
            mode_d = mode_q;
        end

        sync1_d = gpio_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;

        // Detection uses the configuration in force this cycle; a set beats a clear.
        hit0_s  = edge_hit(sel0_q, emode0_q, sync2_q, prev_q);
        hit1_s  = edge_hit(sel1_q, emode1_q, sync2_q, prev_q);
        w1c0_s  = wr_ok_s & (addr[3:2] == REG_INTCFG) & wr_strobe[0] & wr_data[7];
        w1c1_s  = wr_ok_s & (addr[3:2] == REG_INTCFG) & wr_strobe[1] & wr_data[15];
        pend0_d = hit0_s | (pend0_q & ~w1c0_s);
        pend1_d = hit1_s | (pend1_q & ~w1c1_s);

        case (addr[3:2])
            REG_MODE:   rd_word_s = zext(mode_q);
            REG_IDATA:  rd_word_s = zext(sync2_q);
            REG_ODATA:  rd_word_s = zext(odata_q);
            REG_INTCFG: rd_word_s = {16'h0000, pend1_q, emode1_q, sel1_q,
                                     pend0_q, emode0_q, sel0_q};
            default:    rd_word_s = 32'h0000_0000;
        endcase

        rd_valid_d = rd_en;
        err_d      = (rd_en | wr_en) & ~addr_ok_s;
        if (rd_ok_s) begin
            rd_data_d = rd_word_s;
        end else begin
            rd_data_d = 32'h0000_0000;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_q     <= '0;
            odata_q    <= OUT_RESET[WIDTH-1:0];
            sync1_q    <= '0;
            sync2_q    <= '0;
            prev_q     <= '0;
            sel0_q     <= 5'd0;
            sel1_q     <= 5'd0;
            emode0_q   <= 2'd0;
            emode1_q   <= 2'd0;
            pend0_q    <= 1'b0;
            pend1_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 32'h0000_0000;
            err_q      <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            odata_q    <= odata_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
            sel0_q     <= sel0_d;
            sel1_q     <= sel1_d;
            emode0_q   <= emode0_d;
            emode1_q   <= emode1_d;
            pend0_q    <= pend0_d;
            pend1_q    <= pend1_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            err_q      <= err_d;
        end
    end

    assign gpio_oe  = mode_q;
    assign gpio_out = odata_q;
    assign irq0     = pend0_q;
    assign irq1     = pend1_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign err      = err_q;

endmodule
